// File: rtl/fft72_pkg.sv
// Shared constants and types for the 72-point (8x9) FFT twiddle stage.
// Pure declarations: no logic and no latency.
package fft72_pkg;

    localparam int FFT_N       = 72;
    localparam int N_ROW       = 8;
    localparam int N_COL       = 9;
    localparam int TW_FRAC     = 10;
    localparam int TW_ADDR_W   = 11;
    localparam int TW_MAX_EXP  = (N_ROW - 1) * (N_COL - 1);
    localparam int ROW_W       = $clog2(N_ROW);
    localparam int COL_W       = $clog2(N_COL);
    localparam int ACC_W       = $clog2(TW_MAX_EXP + 1);

    // Frame position markers carried alongside each sample.
    typedef struct packed {
        logic sof;
        logic eof;
    } frame_tag_t;

    // Raw product width: DW x TWW signed multiply.
    function automatic int prod_width(input int dw, input int tww);
        return dw + tww;
    endfunction

    // Width of the sum/difference of two products before rounding.
    function automatic int sum_width(input int dw, input int tww);
        return dw + tww + 1;
    endfunction

    // Width of the rounded, saturated result.
    function automatic int sat_width(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/fft72_twiddle_mult_if.sv
// Sample-in / sample-out stream and twiddle table lookup bundle.
// Pure wiring: no latency; valid/ready on both streams.
interface fft72_twiddle_mult_if
    import fft72_pkg::*;
#(
    parameter int DW  = 18,
    parameter int TWW = 18
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sof;
    logic signed [DW-1:0]    in_re;
    logic signed [DW-1:0]    in_im;

    logic [TW_ADDR_W-1:0]    tw_addr;
    logic signed [TWW-1:0]   tw_re;
    logic signed [TWW-1:0]   tw_im;

    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sof;
    logic                    out_eof;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;

    // Environment side: sample source, twiddle ROM and sample sink.
    modport master (
        output in_valid, in_sof, in_re, in_im,
        output tw_re, tw_im,
        output out_ready,
        input  in_ready, tw_addr,
        input  out_valid, out_sof, out_eof, out_re, out_im
    );

    // Twiddle multiplier side.
    modport slave (
        input  in_valid, in_sof, in_re, in_im,
        input  tw_re, tw_im,
        input  out_ready,
        output in_ready, tw_addr,
        output out_valid, out_sof, out_eof, out_re, out_im
    );

endinterface

// File: rtl/fft72_twiddle_mult_cmult.sv
// Complex multiply with round-half-up and saturation; 2 cycles (product reg, result reg).
// Backpressure: every register holds while en is low.
module cmult_rnd_sat
    import fft72_pkg::*;
#(
    parameter int DW      = 18,
    parameter int TWW     = 18,
    parameter int TW_FRAC = fft72_pkg::TW_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_vld,
    input  frame_tag_t            in_tag,
    input  logic signed [DW-1:0]  a,
    input  logic signed [DW-1:0]  b,
    input  logic signed [TWW-1:0] wr,
    input  logic signed [TWW-1:0] wi,
    output logic                  out_vld,
    output frame_tag_t            out_tag,
    output logic signed [DW-1:0]  out_re,
    output logic signed [DW-1:0]  out_im
);

    localparam int PW = prod_width(DW, TWW);
    localparam int SW = sum_width(DW, TWW);
    localparam int RW = sat_width(DW);

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [SW-1:0] RND     = {{(SW-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

    logic                 s2_vld;
    frame_tag_t           s2_tag;
    logic signed [PW-1:0] p_ar;
    logic signed [PW-1:0] p_bi;
    logic signed [PW-1:0] p_ai;
    logic signed [PW-1:0] p_br;

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] sh_re;
    logic signed [SW-1:0] sh_im;

    function automatic logic signed [RW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[RW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[RW-1:0];
        end
        return v[RW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_tag <= '0;
            p_ar   <= '0;
            p_bi   <= '0;
            p_ai   <= '0;
            p_br   <= '0;
        end else if (en) begin
            s2_vld <= in_vld;
            s2_tag <= in_tag;
            p_ar   <= PW'(a) * PW'(wr);
            p_bi   <= PW'(b) * PW'(wi);
            p_ai   <= PW'(a) * PW'(wi);
            p_br   <= PW'(b) * PW'(wr);
        end
    end

    // One guard bit above the products keeps the sum exact before the shift.
    always_comb begin
        sum_re = $signed({p_ar[PW-1], p_ar}) - $signed({p_bi[PW-1], p_bi}) + RND;
        sum_im = $signed({p_ai[PW-1], p_ai}) + $signed({p_br[PW-1], p_br}) + RND;
        sh_re  = sum_re >>> TW_FRAC;
        sh_im  = sum_im >>> TW_FRAC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_tag <= '0;
            out_re  <= '0;
            out_im  <= '0;
        end else if (en) begin
            out_vld <= s2_vld;
            out_tag <= s2_tag;
            out_re  <= sat(sh_re);
            out_im  <= sat(sh_im);
        end
    end

endmodule

// File: rtl/fft72_twiddle_mult.sv
// Twiddle multiply for the 8x9 72-point FFT: index tracking, table address, 3-cycle pipeline.
// Backpressure: whole pipe and counters stall while out_valid && !out_ready; in_ready mirrors that.
module fft72_twiddle_mult
    import fft72_pkg::*;
#(
    parameter int DW      = 18,
    parameter int TWW     = 18,
    parameter int TW_FRAC = fft72_pkg::TW_FRAC
) (
    input  logic clk,
    input  logic rst_n,
    fft72_twiddle_mult_if.slave bus
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);

    logic                    en;
    logic                    in_fire;
    logic                    first;
    logic                    last;

    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [ACC_W-1:0]        acc;

    logic                    s1_vld;
    frame_tag_t              s1_tag;
    logic signed [DW-1:0]    s1_a;
    logic signed [DW-1:0]    s1_b;
    logic signed [TWW-1:0]   s1_wr;
    logic signed [TWW-1:0]   s1_wi;

    logic                    out_vld;
    frame_tag_t              out_tag;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;

    assign en           = !out_vld || bus.out_ready;
    assign in_fire      = bus.in_valid && en;
    assign bus.in_ready = en;

    assign first = bus.in_sof || (row == '0 && col == '0);
    assign last  = !bus.in_sof && row == ROW_LAST && col == COL_LAST;

    // acc always equals row*col for the sample currently at the input.
    assign bus.tw_addr = bus.in_sof ? '0 : TW_ADDR_W'(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            acc <= '0;
        end else if (in_fire) begin
            if (bus.in_sof) begin
                row <= '0;
                col <= COL_W'(1);
                acc <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                acc <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
                acc <= acc + ACC_W'(row);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_tag <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_wr  <= '0;
            s1_wi  <= '0;
        end else if (en) begin
            s1_vld     <= bus.in_valid;
            s1_tag.sof <= first;
            s1_tag.eof <= last;
            s1_a       <= bus.in_re;
            s1_b       <= bus.in_im;
            s1_wr      <= bus.tw_re;
            s1_wi      <= bus.tw_im;
        end
    end

    cmult_rnd_sat #(
        .DW      (DW),
        .TWW     (TWW),
        .TW_FRAC (TW_FRAC)
    ) u_cmult (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_vld  (s1_vld),
        .in_tag  (s1_tag),
        .a       (s1_a),
        .b       (s1_b),
        .wr      (s1_wr),
        .wi      (s1_wi),
        .out_vld (out_vld),
        .out_tag (out_tag),
        .out_re  (out_re),
        .out_im  (out_im)
    );

    assign bus.out_valid = out_vld;
    assign bus.out_sof   = out_tag.sof;
    assign bus.out_eof   = out_tag.eof;
    assign bus.out_re    = out_re;
    assign bus.out_im    = out_im;

endmodule

// File: tb/tb_fft72_twiddle_mult.sv
// Bench for fft72_twiddle_mult: random and directed streams against a behavioural frame model.
module tb_fft72_twiddle_mult;
    import fft72_pkg::*;

    localparam int DW   = 18;
    localparam int TWW  = 18;
    localparam int SMAX = 131071;
    localparam int SMIN = -131072;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft72_twiddle_mult_if #(.DW(DW), .TWW(TWW)) bus ();

    fft72_twiddle_mult #(.DW(DW), .TWW(TWW), .TW_FRAC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int re;
        int im;
        bit sof;
        bit eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tab_re[0:56];
    int   tab_im[0:56];
    int   checks   = 0;
    int   failures = 0;
    int   m_idx    = 0;
    int   m_addr   = 0;
    bit   o_in_fire, o_out_fire, o_sof, o_eof, e_have;
    int   o_addr, o_re, o_im;
    int   obs_re[0:199];
    int   obs_im[0:199];
    bit   obs_sof[0:199];
    bit   obs_eof[0:199];
    int   addr_log[0:199];

    // Twiddle ROM, answered combinationally.
    always_comb begin
        bus.tw_re = '0;
        bus.tw_im = '0;
        if (bus.tw_addr <= 11'd56) begin
            bus.tw_re = TWW'(tab_re[bus.tw_addr]);
            bus.tw_im = TWW'(tab_im[bus.tw_addr]);
        end
    end

    function automatic int clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return int'(v);
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // Frame index i -> row i/9, column i%9, twiddle exponent row*col; round half up.
    function automatic void model_accept(input bit sof, input int a, input int b);
        longint pr, pi;
        exp_t   x;
        if (sof) m_idx = 0;
        m_addr = (m_idx / N_COL) * (m_idx % N_COL);
        pr = longint'(a) * tab_re[m_addr] - longint'(b) * tab_im[m_addr];
        pi = longint'(a) * tab_im[m_addr] + longint'(b) * tab_re[m_addr];
        x.re  = clamp(longint'($floor(real'(pr) / 1024.0 + 0.5)));
        x.im  = clamp(longint'($floor(real'(pi) / 1024.0 + 0.5)));
        x.sof = (m_idx == 0);
        x.eof = (m_idx == FFT_N - 1);
        exp_q.push_back(x);
        m_idx = (m_idx + 1) % FFT_N;
    endfunction

    // One clock: drive at negedge, sample just after, then advance to the next negedge.
    task automatic cycle(input bit v, input bit sof, input int a, input int b, input bit ordy);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_re     = DW'(a);
        bus.in_im     = DW'(b);
        bus.out_ready = ordy;
        #1;
        o_in_fire  = v && bus.in_ready;
        o_out_fire = bus.out_valid && ordy;
        o_addr     = int'(bus.tw_addr);
        o_re       = int'(bus.out_re);
        o_im       = int'(bus.out_im);
        o_sof      = bus.out_sof;
        o_eof      = bus.out_eof;
        e_have     = 1'b0;
        if (o_out_fire && exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            e_have = 1'b1;
        end
        if (o_in_fire) model_accept(sof, a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sof !== 1'b0) begin failures++; $display("FAIL reset_out_sof: got %b want 0", bus.out_sof); end
        checks++; if (bus.out_eof !== 1'b0) begin failures++; $display("FAIL reset_out_eof: got %b want 0", bus.out_eof); end
        checks++; if (bus.out_re !== '0 || bus.out_im !== '0) begin failures++; $display("FAIL reset_out_data: got %0d,%0d want 0,0", bus.out_re, bus.out_im); end
        checks++; if (bus.tw_addr !== '0) begin failures++; $display("FAIL reset_tw_addr: got %0d want 0", bus.tw_addr); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat = -1;
        int lre = 0, lim = 0;
        bit lsof = 1'b0;
        cycle(1'b1, 1'b1, 1000, -500, 1'b1);
        checks++; if (!o_in_fire || o_addr !== 0) begin failures++; $display("FAIL identity_addr: fire=%b addr=%0d want fire=1 addr=0", o_in_fire, o_addr); end
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (o_out_fire && lat < 0) begin
                lat = k; lre = o_re; lim = o_im; lsof = o_sof;
            end
        end
        checks++; if (lat !== 3) begin failures++; $display("FAIL identity_latency: got %0d want 3", lat); end
        checks++; if (lre !== 1000 || lim !== -500 || lsof !== 1'b1) begin failures++; $display("FAIL identity_out: got %0d,%0d sof=%b want 1000,-500 sof=1", lre, lim, lsof); end
    endtask

    task automatic test_points();
        int n_out = 0;
        int a, b;
        for (int k = 0; k < 91; k++) begin
            if (k < 83) begin
                a = rnd_s(); b = rnd_s();
                if (k == 10 || k == 71) begin a = 1024; b = 0; end
                if (k == 82) begin a = -131072; b = -131072; end
                cycle(1'b1, k == 0, a, b, 1'b1);
                addr_log[k] = o_addr;
            end else begin
                cycle(1'b0, 1'b0, 0, 0, 1'b1);
            end
            if (o_out_fire) begin
                checks++;
                if (!e_have || o_re !== e.re || o_im !== e.im || o_sof !== e.sof || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL points_out[%0d]: got %0d,%0d sof=%b eof=%b want %0d,%0d sof=%b eof=%b have=%b",
                             n_out, o_re, o_im, o_sof, o_eof, e.re, e.im, e.sof, e.eof, e_have);
                end
                if (n_out < 200) begin
                    obs_re[n_out] = o_re; obs_im[n_out] = o_im; obs_sof[n_out] = o_sof; obs_eof[n_out] = o_eof;
                end
                n_out++;
            end
        end
        checks++; if (n_out !== 83) begin failures++; $display("FAIL points_count: got %0d want 83", n_out); end
        checks++; if (addr_log[10] !== 1) begin failures++; $display("FAIL addr_i10: got %0d want 1", addr_log[10]); end
        checks++; if (addr_log[71] !== 56) begin failures++; $display("FAIL addr_i71: got %0d want 56", addr_log[71]); end
        checks++; if (addr_log[72] !== 0 || addr_log[81] !== 0 || addr_log[82] !== 1) begin
            failures++; $display("FAIL addr_wrap: got %0d,%0d,%0d want 0,0,1", addr_log[72], addr_log[81], addr_log[82]);
        end
        checks++; if (obs_re[10] !== 1020 || obs_im[10] !== -90) begin failures++; $display("FAIL out_i10: got %0d,%0d want 1020,-90", obs_re[10], obs_im[10]); end
        checks++; if (obs_re[71] !== 177 || obs_im[71] !== 1008 || obs_eof[71] !== 1'b1) begin
            failures++; $display("FAIL out_i71: got %0d,%0d eof=%b want 177,1008 eof=1", obs_re[71], obs_im[71], obs_eof[71]);
        end
        checks++; if (obs_sof[72] !== 1'b1 || obs_eof[72] !== 1'b0) begin failures++; $display("FAIL wrap_sof: got sof=%b eof=%b want 1,0", obs_sof[72], obs_eof[72]); end
        checks++; if (obs_re[82] !== -131072 || obs_im[82] !== -119040) begin
            failures++; $display("FAIL saturation: got %0d,%0d want -131072,-119040", obs_re[82], obs_im[82]);
        end
    endtask

    task automatic test_back_to_back();
        int n_out = 0;
        int n_ready = 0;
        for (int k = 0; k < 150; k++) begin
            if (k < 144) cycle(1'b1, k == 0, rnd_s(), rnd_s(), 1'b1);
            else         cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (k < 144 && o_in_fire) n_ready++;
            if (o_out_fire) begin
                checks++;
                if (!e_have || o_re !== e.re || o_im !== e.im || o_sof !== e.sof || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL b2b_out[%0d]: got %0d,%0d sof=%b eof=%b want %0d,%0d sof=%b eof=%b have=%b",
                             n_out, o_re, o_im, o_sof, o_eof, e.re, e.im, e.sof, e.eof, e_have);
                end
                n_out++;
            end
        end
        checks++; if (n_ready !== 144) begin failures++; $display("FAIL b2b_accept: got %0d want 144", n_ready); end
        checks++; if (n_out !== 144 || exp_q.size() !== 0) begin failures++; $display("FAIL b2b_count: got %0d left=%0d want 144 left=0", n_out, exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int n_out = 0;
        int cyc = 0;
        bit v, r;
        while ((sent < 72 || exp_q.size() > 0) && cyc < 3000) begin
            v = (sent < 72) && ($urandom_range(0, 99) < 70);
            r = (sent >= 72) || ($urandom_range(0, 99) < 50);
            cycle(v, sent == 0, rnd_s(), rnd_s(), r);
            if (o_in_fire) sent++;
            if (o_out_fire) begin
                checks++;
                if (!e_have || o_re !== e.re || o_im !== e.im || o_sof !== e.sof || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL bp_out[%0d]: got %0d,%0d sof=%b eof=%b want %0d,%0d sof=%b eof=%b have=%b",
                             n_out, o_re, o_im, o_sof, o_eof, e.re, e.im, e.sof, e.eof, e_have);
                end
                n_out++;
            end
            cyc++;
        end
        repeat (4) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (o_out_fire) n_out++;
        end
        checks++; if (sent !== 72 || n_out !== 72) begin failures++; $display("FAIL bp_count: sent=%0d out=%0d want 72,72", sent, n_out); end
    endtask

    task automatic test_resync_reset();
        int k = 0;
        int n_out = 0;
        int cyc = 0;
        while (k < 41 && cyc < 200) begin
            cycle(1'b1, k == 0 || k == 30, rnd_s(), rnd_s(), 1'b1);
            if (o_in_fire) begin
                if (k == 30) begin checks++; if (o_addr !== 0) begin failures++; $display("FAIL resync_addr_sof: got %0d want 0", o_addr); end end
                if (k == 40) begin checks++; if (o_addr !== 1) begin failures++; $display("FAIL resync_addr_i10: got %0d want 1", o_addr); end end
                k++;
            end
            if (o_out_fire) begin
                checks++;
                if (!e_have || o_re !== e.re || o_im !== e.im || o_sof !== e.sof || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL resync_out: got %0d,%0d sof=%b eof=%b want %0d,%0d sof=%b eof=%b have=%b",
                             o_re, o_im, o_sof, o_eof, e.re, e.im, e.sof, e.eof, e_have);
                end
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.tw_addr !== '0) begin failures++; $display("FAIL rst_async: out_valid=%b tw_addr=%0d want 0,0", bus.out_valid, bus.tw_addr); end
        exp_q.delete();
        m_idx = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1);
            checks++; if (o_out_fire !== 1'b0) begin failures++; $display("FAIL rst_flush[%0d]: out_valid=1 want 0", j); end
        end
        for (int j = 0; j < 18; j++) begin
            if (j < 12) cycle(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b1);
            else        cycle(1'b0, 1'b0, 0, 0, 1'b1);
            if (j == 0) begin checks++; if (o_addr !== 0) begin failures++; $display("FAIL rst_first_addr: got %0d want 0", o_addr); end end
            if (j == 10) begin checks++; if (o_addr !== 1) begin failures++; $display("FAIL rst_addr_i10: got %0d want 1", o_addr); end end
            if (o_out_fire) begin
                checks++;
                if (!e_have || o_re !== e.re || o_im !== e.im || o_sof !== e.sof || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL rst_out[%0d]: got %0d,%0d sof=%b eof=%b want %0d,%0d sof=%b eof=%b have=%b",
                             n_out, o_re, o_im, o_sof, o_eof, e.re, e.im, e.sof, e.eof, e_have);
                end
                n_out++;
            end
        end
        checks++; if (n_out !== 12 || exp_q.size() !== 0) begin failures++; $display("FAIL rst_count: got %0d left=%0d want 12 left=0", n_out, exp_q.size()); end
    endtask

    initial begin
        for (int k = 0; k <= 56; k++) begin
            tab_re[k] = int'($urandom_range(0, 3000)) - 1500;
            tab_im[k] = int'($urandom_range(0, 3000)) - 1500;
        end
        tab_re[0]  = 1024; tab_im[0]  = 0;
        tab_re[1]  = 1020; tab_im[1]  = -90;
        tab_re[56] = 177;  tab_im[56] = 1008;

        test_reset();
        test_identity();
        test_points();
        test_back_to_back();
        test_backpressure();
        test_resync_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fft72_twiddle_mult.md
FFT72_TWIDDLE_MULT -- requirements
Module: fft72_twiddle_mult

Interface
REQ-001 Parameter DW, default 18, sample component width (signed, two's complement).
REQ-002 Parameter TWW, default 18, twiddle component width (signed).
REQ-003 Parameter TW_FRAC, default 10, twiddle fraction bits (1.0 = 1024).
REQ-004 Port clk  input  1  master clock; all state on rising edge; the block has one clock.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port in_valid  input  1  input sample valid.
REQ-007 Port in_ready  output  1  block accepts the sample this cycle.
REQ-008 Port in_sof  input  1  input sample is index 0 of a 72-sample frame.
REQ-009 Port in_re / in_im  input  DW each  input sample.
REQ-010 Port tw_addr  output  11  twiddle table address, range 0..56.
REQ-011 Port tw_re / tw_im  input  TWW each  twiddle returned combinationally for tw_addr.
REQ-012 Port out_valid  output  1  output sample valid.
REQ-013 Port out_ready  input  1  downstream accepts output.
REQ-014 Port out_sof / out_eof  output  1 each  output sample is frame index 0 / 71.
REQ-015 Port out_re / out_im  output  DW each  twiddled sample.

Function
REQ-016 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-017 Frame index i = 9*r + c, r in 0..7 (row counter), c in 0..8 (column counter); counters advance only on input transfer; c wraps 8->0 with r increment; r wraps 7->0 after i=71.
REQ-018 Twiddle exponent SHALL be r*c, held in an accumulator: cleared when c wraps, incremented by r when c increments; no multiplier for the address.
REQ-019 tw_addr = 0 when in_sof is high, else the accumulator; in_sof on a transfer forces that sample to i=0 (r=0,c=0) and the next to i=1 (resynchronises mid-frame).
REQ-020 Three-stage pipeline: S1 registers sample, tw_re/tw_im, sof, eof; S2 registers the four DW x TWW products; S3 registers rounded, saturated results.
REQ-021 out_re = sat(round((a*wr - b*wi) / 2^TW_FRAC)), out_im = sat(round((a*wi + b*wr) / 2^TW_FRAC)), a=in_re, b=in_im.
REQ-022 Rounding: add 2^(TW_FRAC-1) to the full-width (DW+TWW+1) sum, then arithmetic shift right TW_FRAC.
REQ-023 Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 Latency: sample accepted at cycle T appears on outputs at T+3 when no back-pressure.
REQ-025 Stall: en = !out_valid || out_ready; when en=0 all stages and counters hold; in_ready = en.
REQ-026 Back-to-back transfers at one sample per clock SHALL be sustained while out_ready=1.
REQ-027 Valid bits propagate per stage; bubbles (in_valid=0) propagate as out_valid=0 without loss of data order.
REQ-028 Simultaneous in_sof and counter wrap: in_sof wins.

Reset
REQ-029 rst_n low clears r, c, accumulator, all stage valid bits; out_valid=0, out_sof=0, out_eof=0, out_re=out_im=0, tw_addr=0.
REQ-030 Reset mid-frame discards all in-flight samples; first sample after release is i=0 regardless of in_sof.

Structure
REQ-031 Shared package fft72_pkg holds FFT_N=72, N_ROW=8, N_COL=9, TW_FRAC and the saturate/round width constants.
REQ-032 One sub-module, cmult_rnd_sat (S2+S3 complex multiply, round, saturate), instantiated once; counters and handshake in the top.

Verification
REQ-033 Identity: sof sample (1000,-500) at i=0 -> tw_addr=0, output (1000,-500) exactly 3 cycles later, out_sof=1.
REQ-034 Index 10 (r=1,c=1) input (1024,0), table (1020,-90) -> tw_addr=1, output (1020,-90).
REQ-035 Index 71 (r=7,c=8) input (1024,0), table (177,1008) -> tw_addr=56, output (177,1008), out_eof=1; next sample addr 0.
REQ-036 Saturation at index 10: input (-131072,-131072) -> out_re=-131072 (clamped from -142080), out_im=-119040.
REQ-037 Back-pressure: full frame with out_ready toggling randomly and in_valid gaps -> 72 outputs, order and values match golden model, no drops or duplicates.
REQ-038 Mid-frame in_sof at i=30 and rst_n pulse at i=40 -> counter restarts at 0 each time; pipeline flushed after reset.
